// File: rtl/fifo_burst_writer_pkg.sv
// Shared definitions for the FIFO write-side burst producer.
// Defaults match the companion async FIFO package.
package fifo_burst_writer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_MAX_BYTES  = 2;

    // Bits needed to index 'value' distinct codes (0 .. value-1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_burst_writer.sv
// Accepts a multi-byte word over valid/ready and writes it LSB-first into the
// async FIFO write port, one byte per cycle, stalling on wfull.
module fifo_burst_writer
    import fifo_burst_writer_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int MAX_BYTES  = FIFO_MAX_BYTES,
    parameter int LEN_W      = clog2(MAX_BYTES + 1)
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] in_data,
    input  logic [LEN_W-1:0]                in_len,
    output logic                            in_ready,
    input  logic                            wfull,
    output logic                            winc,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic                            busy,
    output logic                            done,
    output logic                            len_err
);

    localparam int WORD_W = DATA_WIDTH * MAX_BYTES;
    localparam int CNT_W  = clog2(MAX_BYTES + 1);

    state_t            state_q, state_n;
    logic [WORD_W-1:0] shift_q, shift_n;
    logic [CNT_W-1:0]  rem_q,   rem_n;
    logic              done_n;
    logic              len_err_n;
    logic [CNT_W-1:0]  len_eff;
    logic              accept;
    logic              last_byte;
    int                len_in;

    assign last_byte = (rem_q == CNT_W'(1));
    assign winc      = (state_q == PUSH) && !wfull;
    assign wdata     = shift_q[DATA_WIDTH-1:0];
    assign in_ready  = (state_q == IDLE) || ((state_q == PUSH) && last_byte && !wfull);
    assign busy      = (state_q == PUSH);
    assign accept    = in_valid && in_ready;

    always_comb begin
        len_in  = int'(in_len);
        len_eff = CNT_W'((len_in > MAX_BYTES) ? MAX_BYTES : len_in);
    end

    always_comb begin
        state_n   = state_q;
        shift_n   = shift_q;
        rem_n     = rem_q;
        done_n    = 1'b0;
        len_err_n = 1'b0;

        if (winc) begin
            shift_n = shift_q >> DATA_WIDTH;
            rem_n   = rem_q - CNT_W'(1);
            if (last_byte) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
        end

        // A word accepted on the last byte's edge reloads with no bubble.
        if (accept) begin
            if (len_eff == '0) begin
                len_err_n = 1'b1;
            end else begin
                shift_n = in_data;
                rem_n   = len_eff;
                state_n = PUSH;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            done    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            rem_q   <= rem_n;
            done    <= done_n;
            len_err <= len_err_n;
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: handshake, byte order, stalls,
// length edge cases and asynchronous reset mid-burst.
module tb_fifo_burst_writer;

    logic        wclk;
    logic        wrst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_len;
    logic        in_ready;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        len_err;

    int total;
    int bad;
    logic [7:0] wr_q[$];

    fifo_burst_writer dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_len   (in_len),
        .in_ready (in_ready),
        .wfull    (wfull),
        .winc     (winc),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .len_err  (len_err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Inputs only change just after posedge, so negedge values hold through the write edge.
    always @(negedge wclk) begin
        if (wrst_n && winc) wr_q.push_back(wdata);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge wclk);
        #1;
    endtask

    task automatic offer(input logic [15:0] d, input logic [1:0] l);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        wrst_n   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '0;
        wfull    = 1'b0;
        #3;
        chk("rst_winc", winc, 0);
        chk("rst_wdata", wdata, 8'h00);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lenerr", len_err, 0);
        cyc();
        wrst_n = 1'b1;
        cyc();

        // Single word
        wr_q.delete();
        offer(16'hA55A, 2'd2);
        #1;
        chk("sw_idle_winc", winc, 0);
        cyc();
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        #1;
        chk("sw_c1_winc", winc, 1);
        chk("sw_c1_wdata", wdata, 8'h5A);
        chk("sw_c1_ready", in_ready, 0);
        chk("sw_c1_busy", busy, 1);
        cyc();
        chk("sw_c2_winc", winc, 1);
        chk("sw_c2_wdata", wdata, 8'hA5);
        chk("sw_c2_ready", in_ready, 1);
        cyc();
        chk("sw_c3_done", done, 1);
        chk("sw_c3_busy", busy, 0);
        chk("sw_c3_winc", winc, 0);
        cyc();
        chk("sw_c4_done", done, 0);
        chk("sw_n", wr_q.size(), 2);
        chk("sw_b0", wr_q[0], 8'h5A);
        chk("sw_b1", wr_q[1], 8'hA5);

        // Backpressure
        wr_q.delete();
        offer(16'hA55A, 2'd2);
        cyc();
        in_valid = 1'b0;
        wfull    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_stall_winc", winc, 0);
            chk("bp_stall_wdata", wdata, 8'h5A);
            chk("bp_stall_ready", in_ready, 0);
            cyc();
        end
        wfull = 1'b0;
        #1;
        chk("bp_r1_winc", winc, 1);
        chk("bp_r1_wdata", wdata, 8'h5A);
        cyc();
        chk("bp_r2_wdata", wdata, 8'hA5);
        cyc();
        chk("bp_done", done, 1);
        cyc();
        chk("bp_n", wr_q.size(), 2);
        chk("bp_b0", wr_q[0], 8'h5A);
        chk("bp_b1", wr_q[1], 8'hA5);

        // Back-to-back words, no bubble
        wr_q.delete();
        offer(16'hA55A, 2'd2);
        cyc();
        in_data = 16'h1234;
        #1;
        chk("bb_c1_wdata", wdata, 8'h5A);
        chk("bb_c1_ready", in_ready, 0);
        cyc();
        chk("bb_c2_wdata", wdata, 8'hA5);
        chk("bb_c2_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("bb_c3_winc", winc, 1);
        chk("bb_c3_wdata", wdata, 8'h34);
        chk("bb_c3_done", done, 1);
        cyc();
        chk("bb_c4_wdata", wdata, 8'h12);
        chk("bb_c4_done", done, 0);
        cyc();
        chk("bb_c5_done", done, 1);
        chk("bb_c5_busy", busy, 0);
        cyc();
        chk("bb_n", wr_q.size(), 4);
        chk("bb_b0", wr_q[0], 8'h5A);
        chk("bb_b1", wr_q[1], 8'hA5);
        chk("bb_b2", wr_q[2], 8'h34);
        chk("bb_b3", wr_q[3], 8'h12);

        // Length 1
        wr_q.delete();
        offer(16'h00C3, 2'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("l1_wdata", wdata, 8'hC3);
        chk("l1_ready", in_ready, 1);
        cyc();
        chk("l1_done", done, 1);
        chk("l1_busy", busy, 0);
        cyc();
        chk("l1_n", wr_q.size(), 1);
        chk("l1_b0", wr_q[0], 8'hC3);

        // Length 0
        wr_q.delete();
        offer(16'h7777, 2'd0);
        #1;
        chk("l0_ready_pre", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("l0_lenerr", len_err, 1);
        chk("l0_winc", winc, 0);
        chk("l0_busy", busy, 0);
        chk("l0_ready", in_ready, 1);
        chk("l0_done", done, 0);
        cyc();
        chk("l0_lenerr_clr", len_err, 0);
        cyc();
        chk("l0_n", wr_q.size(), 0);

        // Length 3 clamps to 2
        wr_q.delete();
        offer(16'h1234, 2'd3);
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("l3_done", done, 1);
        cyc();
        cyc();
        chk("l3_n", wr_q.size(), 2);
        chk("l3_b0", wr_q[0], 8'h34);
        chk("l3_b1", wr_q[1], 8'h12);

        // Reset mid-burst
        wr_q.delete();
        offer(16'hA55A, 2'd2);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("mr_first", wdata, 8'h5A);
        cyc();
        wrst_n = 1'b0;
        #1;
        chk("mr_winc", winc, 0);
        chk("mr_wdata", wdata, 8'h00);
        chk("mr_ready", in_ready, 1);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_lenerr", len_err, 0);
        cyc();
        wrst_n = 1'b1;
        cyc();
        chk("mr_idle_busy", busy, 0);
        offer(16'hBEEF, 2'd2);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("mr_n1_wdata", wdata, 8'hEF);
        cyc();
        chk("mr_n2_wdata", wdata, 8'hBE);
        cyc();
        chk("mr_n_done", done, 1);
        cyc();
        chk("mr_n", wr_q.size(), 3);
        chk("mr_b0", wr_q[0], 8'h5A);
        chk("mr_b1", wr_q[1], 8'hEF);
        chk("mr_b2", wr_q[2], 8'hBE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
